// File: rtl/inst_encoder.sv
// Two-stage RV64I instruction encoder: field bundle in, 32-bit instruction word out.
// Define ENCODER_RV64W_EN to also encode OP-IMM-32 / OP-32 (RV64 word ops).
module inst_encoder (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
);

    typedef enum logic [6:0] {
        OPC_LUI        = 7'b0110111,
        OPC_AUIPC      = 7'b0010111,
        OPC_JAL        = 7'b1101111,
        OPC_JALR       = 7'b1100111,
        OPC_BRANCH     = 7'b1100011,
        OPC_LOAD       = 7'b0000011,
        OPC_STORE      = 7'b0100011,
        OPC_OP_IMM     = 7'b0010011,
        OPC_OP         = 7'b0110011,
        OPC_MISC_MEM   = 7'b0001111,
        OPC_SYSTEM     = 7'b1110011,
        OPC_OP_IMM_32  = 7'b0011011,
        OPC_OP_32      = 7'b0111011
    } opcode_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_funct3;
    logic        s1_alt;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [63:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_inst;
    logic        s2_err;

    logic        s2_ready;
    logic [31:0] word;
    logic        legal;
    logic        fits12, fits13, fits21, fits32;
    logic [31:0] i_word, s_word, b_word, r_word;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;
    assign out_inst  = s2_inst;
    assign out_err   = s2_err;

    // Signed-range checks: all bits above the field's sign bit must equal it.
    assign fits12 = (&s1_imm[63:11]) || !(|s1_imm[63:11]);
    assign fits13 = (&s1_imm[63:12]) || !(|s1_imm[63:12]);
    assign fits21 = (&s1_imm[63:20]) || !(|s1_imm[63:20]);
    assign fits32 = (&s1_imm[63:31]) || !(|s1_imm[63:31]);

    assign i_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
    assign s_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
    assign b_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                     s1_imm[4:1], s1_imm[11], s1_opcode};
    assign r_word = {1'b0, s1_alt, 5'b00000, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (s1_opcode)
            OPC_LUI, OPC_AUIPC: begin
                word  = {s1_imm[31:12], s1_rd, s1_opcode};
                legal = (s1_imm[11:0] == '0) && fits32;
            end
            OPC_JAL: begin
                word  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
                legal = fits21 && !s1_imm[0];
            end
            OPC_JALR: begin
                word  = i_word;
                legal = (s1_funct3 == 3'b000) && fits12;
            end
            OPC_LOAD: begin
                word  = i_word;
                legal = (s1_funct3 != 3'b111) && fits12;
            end
            OPC_STORE: begin
                word  = s_word;
                legal = !s1_funct3[2] && fits12;
            end
            OPC_BRANCH: begin
                word  = b_word;
                legal = (s1_funct3[2:1] != 2'b01) && fits13 && !s1_imm[0];
            end
            OPC_OP_IMM: begin
                case (s1_funct3)
                    3'b001: begin
                        word  = {6'b000000, s1_imm[5:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                        legal = !s1_alt && (s1_imm[63:6] == '0);
                    end
                    3'b101: begin
                        word  = {1'b0, s1_alt, 4'b0000, s1_imm[5:0], s1_rs1, s1_funct3,
                                 s1_rd, s1_opcode};
                        legal = (s1_imm[63:6] == '0);
                    end
                    default: begin
                        word  = i_word;
                        legal = fits12;
                    end
                endcase
            end
            OPC_OP: begin
                word  = r_word;
                legal = !s1_alt || (s1_funct3 == 3'b000) || (s1_funct3 == 3'b101);
            end
            OPC_MISC_MEM: begin
                word  = 32'h0FF0_000F;
                legal = 1'b1;
            end
            OPC_SYSTEM: begin
                word  = s1_alt ? 32'h0010_0073 : 32'h0000_0073;
                legal = 1'b1;
            end
`ifdef ENCODER_RV64W_EN
            OPC_OP_IMM_32: begin
                case (s1_funct3)
                    3'b000: begin
                        word  = i_word;
                        legal = fits12;
                    end
                    3'b001: begin
                        word  = {7'b0000000, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                        legal = !s1_alt && (s1_imm[63:5] == '0);
                    end
                    3'b101: begin
                        word  = {1'b0, s1_alt, 5'b00000, s1_imm[4:0], s1_rs1, s1_funct3,
                                 s1_rd, s1_opcode};
                        legal = (s1_imm[63:5] == '0);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                word  = r_word;
                legal = ((s1_funct3 == 3'b000) || (s1_funct3 == 3'b101))
                     || ((s1_funct3 == 3'b001) && !s1_alt);
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_funct3 <= '0;
            s1_alt    <= 1'b0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
            s2_valid  <= 1'b0;
            s2_inst   <= '0;
            s2_err    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_opcode <= in_opcode;
                    s1_funct3 <= in_funct3;
                    s1_alt    <= in_alt;
                    s1_rd     <= in_rd;
                    s1_rs1    <= in_rs1;
                    s1_rs2    <= in_rs2;
                    s1_imm    <= in_imm;
                end
            end
            // Output word only changes when S2 is empty or being drained.
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_inst <= legal ? word : NOP_WORD;
                    s2_err  <= !legal;
                end
            end
        end
    end

endmodule
